// File: rtl/hunt_pkg.sv
// -----------------------------------------------------------------------------
// hunt_pkg
// Shared types and widths for the duck-hunt round controller.
//   hunt_state_t  : game-flow FSM states
//   AMMO_W        : width of the per-duck shot counter
//   DUCK_CNT_W    : width of the per-round duck counters
//   ROUND_W       : width of the round number
//   round_inc_sat : round increment that sticks at the maximum value
// -----------------------------------------------------------------------------
package hunt_pkg;

    localparam int unsigned AMMO_W     = 2;
    localparam int unsigned DUCK_CNT_W = 4;
    localparam int unsigned ROUND_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_HIT,
        S_ESC,
        S_ROUND_END,
        S_OVER
    } hunt_state_t;

    function automatic logic [ROUND_W-1:0] round_inc_sat(input logic [ROUND_W-1:0] r);
        return (r == {ROUND_W{1'b1}}) ? r : r + 1'b1;
    endfunction

endpackage

// File: rtl/hunt_score_acc.sv
// -----------------------------------------------------------------------------
// hunt_score_acc
// Score register with a saturating adder. Clear wins over add.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : load zero on the next edge
//   add_en     : add add_val on the next edge (saturating at all-ones)
//   add_val    : amount to add
//   score      : current score
// -----------------------------------------------------------------------------
module hunt_score_acc #(
    parameter int unsigned SCORE_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               add_en,
    input  logic [SCORE_W-1:0] add_val,
    output logic [SCORE_W-1:0] score
);

    logic [SCORE_W-1:0] score_d, score_q;
    logic [SCORE_W:0]   sum;

    always_comb begin
        // One spare bit catches the carry-out that signals overflow.
        sum     = {1'b0, score_q} + {1'b0, add_val};
        score_d = score_q;
        if (clr) begin
            score_d = '0;
        end else if (add_en) begin
            score_d = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/hunt_round_ctl.sv
// -----------------------------------------------------------------------------
// hunt_round_ctl
// Game-flow controller: duck spawn -> shot/escape -> animation -> next duck
// -> round end -> next round or game over. Consumes the trigger controller's
// hit/miss/shot_fired pulses; drives duck motion and the HUD.
//
// Optional feature macro: PERFECT_ROUND_BONUS_EN -- when defined, a round in
// which every duck was hit adds PERFECT_BONUS to the score on entry to
// S_ROUND_END.
//
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start         : begin / restart (honoured in S_IDLE and S_OVER only)
//   hit, miss     : trigger results; hit wins when both are set
//   shot_fired    : consumes one shot if any remain
//   duck_timeout  : duck flew away
//   anim_done     : fall / escape / round animation finished
//   duck_spawn    : one-cycle pulse on the first cycle of each duck
//   duck_kill     : high while the hit duck falls
//   duck_escape   : high while the missed duck flies off
//   ammo          : shots left for the current duck
//   score         : saturating score
//   ducks_done    : ducks finished this round
//   ducks_hit     : ducks hit this round
//   round         : round number, 1-based, saturates at 255
//   round_over    : high in the round summary state
//   game_over     : high once the game is lost
// -----------------------------------------------------------------------------
module hunt_round_ctl
    import hunt_pkg::*;
#(
    parameter int unsigned SHOTS_PER_DUCK  = 3,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned MIN_HITS        = 6,
    parameter int unsigned HIT_POINTS      = 500,
    parameter int unsigned SCORE_W         = 20,
    parameter int unsigned PERFECT_BONUS   = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hit,
    input  logic                  miss,
    input  logic                  shot_fired,
    input  logic                  duck_timeout,
    input  logic                  anim_done,
    output logic                  duck_spawn,
    output logic                  duck_kill,
    output logic                  duck_escape,
    output logic [AMMO_W-1:0]     ammo,
    output logic [SCORE_W-1:0]    score,
    output logic [DUCK_CNT_W-1:0] ducks_done,
    output logic [DUCK_CNT_W-1:0] ducks_hit,
    output logic [ROUND_W-1:0]    round,
    output logic                  round_over,
    output logic                  game_over
);

    localparam logic [AMMO_W-1:0]     Reload    = AMMO_W'(SHOTS_PER_DUCK);
    localparam logic [DUCK_CNT_W-1:0] DuckLimit = DUCK_CNT_W'(DUCKS_PER_ROUND);
    localparam logic [DUCK_CNT_W-1:0] HitsToWin = DUCK_CNT_W'(MIN_HITS);
    localparam logic [SCORE_W-1:0]    HitPts    = SCORE_W'(HIT_POINTS);
`ifdef PERFECT_ROUND_BONUS_EN
    localparam logic [SCORE_W-1:0]    BonusPts  = SCORE_W'(PERFECT_BONUS);
`endif

    // Elaboration-time range checks on the configuration.
    if (SHOTS_PER_DUCK < 1 || SHOTS_PER_DUCK > 3) begin : g_bad_shots
        $error("SHOTS_PER_DUCK must be 1..3");
    end
    if (DUCKS_PER_ROUND < 1 || DUCKS_PER_ROUND > 15) begin : g_bad_ducks
        $error("DUCKS_PER_ROUND must be 1..15");
    end
    if (MIN_HITS > DUCKS_PER_ROUND) begin : g_bad_hits
        $error("MIN_HITS must not exceed DUCKS_PER_ROUND");
    end
    if (SCORE_W < 32 && PERFECT_BONUS >= (32'd1 << SCORE_W)) begin : g_bad_bonus
        $error("PERFECT_BONUS does not fit in SCORE_W bits");
    end

    hunt_state_t           state_d, state_q;
    logic [AMMO_W-1:0]     ammo_d, ammo_q;
    logic [DUCK_CNT_W-1:0] done_d, done_q;
    logic [DUCK_CNT_W-1:0] hits_d, hits_q;
    logic [ROUND_W-1:0]    round_d, round_q;
    logic                  spawn_d, spawn_q;

    logic                  score_clr;
    logic                  score_add_en;
    logic [SCORE_W-1:0]    score_add_val;

    always_comb begin
        state_d       = state_q;
        ammo_d        = ammo_q;
        done_d        = done_q;
        hits_d        = hits_q;
        round_d       = round_q;
        spawn_d       = 1'b0;
        score_clr     = 1'b0;
        score_add_en  = 1'b0;
        score_add_val = '0;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d   = S_ACTIVE;
                    ammo_d    = Reload;
                    done_d    = '0;
                    hits_d    = '0;
                    round_d   = ROUND_W'(1);
                    spawn_d   = 1'b1;
                    score_clr = 1'b1;
                end
            end

            S_ACTIVE: begin
                if (shot_fired && ammo_q != '0) begin
                    ammo_d = ammo_q - 1'b1;
                end
                if (hit) begin
                    state_d       = S_HIT;
                    hits_d        = hits_q + 1'b1;
                    done_d        = done_q + 1'b1;
                    score_add_en  = 1'b1;
                    score_add_val = HitPts;
                end else if ((miss && ammo_d == '0) || duck_timeout) begin
                    // Escape is judged on the ammo left after this shot.
                    state_d = S_ESC;
                    done_d  = done_q + 1'b1;
                end
            end

            S_HIT, S_ESC: begin
                if (anim_done) begin
                    if (done_q == DuckLimit) begin
                        state_d = S_ROUND_END;
`ifdef PERFECT_ROUND_BONUS_EN
                        if (hits_q == DuckLimit) begin
                            score_add_en  = 1'b1;
                            score_add_val = BonusPts;
                        end
`endif
                    end else begin
                        state_d = S_ACTIVE;
                        ammo_d  = Reload;
                        spawn_d = 1'b1;
                    end
                end
            end

            S_ROUND_END: begin
                if (anim_done) begin
                    if (hits_q >= HitsToWin) begin
                        state_d = S_ACTIVE;
                        round_d = round_inc_sat(round_q);
                        done_d  = '0;
                        hits_d  = '0;
                        ammo_d  = Reload;
                        spawn_d = 1'b1;
                    end else begin
                        state_d = S_OVER;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ammo_q  <= '0;
            done_q  <= '0;
            hits_q  <= '0;
            round_q <= '0;
            spawn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ammo_q  <= ammo_d;
            done_q  <= done_d;
            hits_q  <= hits_d;
            round_q <= round_d;
            spawn_q <= spawn_d;
        end
    end

    hunt_score_acc #(
        .SCORE_W (SCORE_W)
    ) u_score_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (score_clr),
        .add_en  (score_add_en),
        .add_val (score_add_val),
        .score   (score)
    );

    assign duck_spawn  = spawn_q;
    assign duck_kill   = (state_q == S_HIT);
    assign duck_escape = (state_q == S_ESC);
    assign round_over  = (state_q == S_ROUND_END);
    assign game_over   = (state_q == S_OVER);
    assign ammo        = ammo_q;
    assign ducks_done  = done_q;
    assign ducks_hit   = hits_q;
    assign round       = round_q;

endmodule

// File: tb/tb_hunt_round_ctl.sv
// -----------------------------------------------------------------------------
// tb_hunt_round_ctl
// Self-checking bench for hunt_round_ctl with a behavioural game model.
// Compile with +define+PERFECT_ROUND_BONUS_EN to match a bonus-enabled build.
// -----------------------------------------------------------------------------
module tb_hunt_round_ctl;

    localparam int    SHOTS     = 3;
    localparam int    DUCKS     = 10;
    localparam int    MIN_HITS  = 6;
    localparam int    HIT_PTS   = 500;
    localparam int    BONUS     = 10000;
    localparam longint SCORE_MAX = (64'd1 << 20) - 1;

    // Game phases of the reference model.
    localparam int PH_IDLE = 0, PH_PLAY = 1, PH_FALL = 2, PH_AWAY = 3, PH_SUMMARY = 4, PH_LOST = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, hit = 1'b0, miss = 1'b0, shot_fired = 1'b0;
    logic        duck_timeout = 1'b0, anim_done = 1'b0;
    logic        duck_spawn, duck_kill, duck_escape, round_over, game_over;
    logic [1:0]  ammo;
    logic [19:0] score;
    logic [3:0]  ducks_done, ducks_hit;
    logic [7:0]  round;

    hunt_round_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hit          (hit),
        .miss         (miss),
        .shot_fired   (shot_fired),
        .duck_timeout (duck_timeout),
        .anim_done    (anim_done),
        .duck_spawn   (duck_spawn),
        .duck_kill    (duck_kill),
        .duck_escape  (duck_escape),
        .ammo         (ammo),
        .score        (score),
        .ducks_done   (ducks_done),
        .ducks_hit    (ducks_hit),
        .round        (round),
        .round_over   (round_over),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model state.
    int     m_phase, m_ammo, m_done, m_hits, m_round;
    longint m_score;
    bit     m_spawn;

    function automatic longint sat_add(input longint a, input longint b);
        return (a + b > SCORE_MAX) ? SCORE_MAX : a + b;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_ammo = 0; m_done = 0; m_hits = 0; m_round = 0;
        m_score = 0; m_spawn = 0;
    endtask

    task automatic new_duck();
        m_phase = PH_PLAY; m_ammo = SHOTS; m_spawn = 1;
    endtask

    task automatic model_step(input bit s, h, m, sf, to, an);
        m_spawn = 0;
        case (m_phase)
            PH_IDLE, PH_LOST: if (s) begin
                m_score = 0; m_round = 1; m_done = 0; m_hits = 0;
                new_duck();
            end
            PH_PLAY: begin
                if (sf && m_ammo > 0) m_ammo--;
                if (h) begin
                    m_score = sat_add(m_score, HIT_PTS);
                    m_hits++; m_done++; m_phase = PH_FALL;
                end else if ((m && m_ammo == 0) || to) begin
                    m_done++; m_phase = PH_AWAY;
                end
            end
            PH_FALL, PH_AWAY: if (an) begin
                if (m_done == DUCKS) begin
                    m_phase = PH_SUMMARY;
`ifdef PERFECT_ROUND_BONUS_EN
                    if (m_hits == DUCKS) m_score = sat_add(m_score, BONUS);
`endif
                end else begin
                    new_duck();
                end
            end
            PH_SUMMARY: if (an) begin
                if (m_hits >= MIN_HITS) begin
                    m_round = (m_round < 255) ? m_round + 1 : 255;
                    m_done = 0; m_hits = 0;
                    new_duck();
                end else begin
                    m_phase = PH_LOST;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check("duck_spawn", duck_spawn, m_spawn);
        check("duck_kill", duck_kill, m_phase == PH_FALL);
        check("duck_escape", duck_escape, m_phase == PH_AWAY);
        check("round_over", round_over, m_phase == PH_SUMMARY);
        check("game_over", game_over, m_phase == PH_LOST);
        check("ammo", ammo, m_ammo);
        check("score", score, m_score);
        check("ducks_done", ducks_done, m_done);
        check("ducks_hit", ducks_hit, m_hits);
        check("round", round, m_round);
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 ns later.
    task automatic cycle(input bit s, h, m, sf, to, an);
        start = s; hit = h; miss = m; shot_fired = sf; duck_timeout = to; anim_done = an;
        @(posedge clk);
        if (!rst) model_reset();
        else model_step(s, h, m, sf, to, an);
        #1;
        start = 0; hit = 0; miss = 0; shot_fired = 0; duck_timeout = 0; anim_done = 0;
        check_all();
    endtask

    task automatic idle();        cycle(0, 0, 0, 0, 0, 0); endtask
    task automatic anim();        cycle(0, 0, 0, 0, 0, 1); endtask
    task automatic shot_miss();   cycle(0, 0, 1, 1, 0, 0); endtask
    task automatic hit_duck();    cycle(0, 1, 0, 1, 0, 0); anim(); endtask
    task automatic escape_duck(); cycle(0, 0, 0, 0, 1, 0); anim(); endtask

    initial begin
        model_reset();
        #7;
        check_all();
        check("reset_score", score, 0);
        rst = 1'b1;

        // Start: spawn pulse, full ammo, round 1.
        cycle(1, 0, 0, 0, 0, 0);
        check("start_spawn", duck_spawn, 1);
        check("start_ammo", ammo, 3);
        check("start_round", round, 1);
        idle();
        check("spawn_one_cycle", duck_spawn, 0);

        // Two misses then a hit: ammo 3->2->1->0, score 500.
        shot_miss();
        check("ammo_after_miss1", ammo, 2);
        shot_miss();
        check("ammo_after_miss2", ammo, 1);
        cycle(0, 1, 0, 1, 0, 0);
        check("ammo_after_hit", ammo, 0);
        check("score_first_hit", score, 500);
        check("kill_level", duck_kill, 1);
        anim();
        check("respawn", duck_spawn, 1);
        check("reload", ammo, 3);

        // Three misses: duck escapes.
        shot_miss(); shot_miss(); shot_miss();
        check("escape_level", duck_escape, 1);
        check("escape_hits", ducks_hit, 1);
        start = 1'b0;
        cycle(1, 1, 0, 0, 0, 0); // start ignored, hit ignored while escaping
        anim();

        // Hit coincident with timeout counts as a hit.
        cycle(0, 1, 0, 1, 1, 0);
        check("hit_beats_timeout", duck_kill, 1);
        anim();

        // Finish the round at 6 hits out of 10.
        repeat (4) hit_duck();
        repeat (3) escape_duck();
        check("round_end_6", round_over, 1);
        anim();
        check("round2", round, 2);
        check("round2_score", score, 3000);
        check("round2_cleared", ducks_done, 0);

        // 5 hits: game over, then restart.
        repeat (5) hit_duck();
        repeat (5) escape_duck();
        anim();
        check("game_over_5", game_over, 1);
        idle();
        cycle(1, 0, 0, 0, 0, 0);
        check("restart_round", round, 1);
        check("restart_score", score, 0);

        // Perfect round.
        repeat (10) hit_duck();
        check("perfect_round_over", round_over, 1);
`ifdef PERFECT_ROUND_BONUS_EN
        check("perfect_score", score, 15000);
`else
        check("perfect_score", score, 5000);
`endif
        anim();

        // Asynchronous reset in the middle of a fall animation.
        cycle(0, 1, 0, 1, 0, 0);
        #3 rst = 1'b0;
        #1 model_reset();
        check_all();
        check("async_rst_kill", duck_kill, 0);
        cycle(0, 1, 0, 1, 0, 1);
        #3 rst = 1'b1;
        cycle(0, 1, 0, 1, 0, 1); // idle: hit and anim_done do nothing
        check("idle_hit_ignored", score, 0);
        cycle(0, 1, 1, 1, 0, 0);
        check("idle_still", duck_spawn, 0);

        // Long perfect game: round and score saturation.
        cycle(1, 0, 0, 0, 0, 0);
        for (int r = 0; r < 258; r++) begin
            repeat (10) hit_duck();
            anim();
        end
        check("round_sat", round, 255);
        check("score_sat", score, SCORE_MAX);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            bit s, h, m, sf, to, an;
            int k;
            s = ($urandom_range(0, 19) == 0);
            k = $urandom_range(0, 9);
            h = 0; m = 0; sf = 0;
            case (k)
                0, 1, 2: begin sf = 1; m = 1; end
                3, 4:    begin sf = 1; h = 1; end
                5:       begin sf = 1; h = 1; m = 1; end
                6:       h = 1;
                7:       m = 1;
                default: ;
            endcase
            to = ($urandom_range(0, 11) == 0);
            an = ($urandom_range(0, 3) == 0);
            cycle(s, h, m, sf, to, an);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
